// File: rtl/muldiv_arbiter.sv
// Round-robin front end sharing one iterative multiplier and one divider among NREQ requesters.
// Optional last-result bypass register: define MULDIV_LASTRES_EN.
module muldiv_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_rs1,
    input  logic [32*NREQ-1:0]   req_rs2,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_result,
    output logic                 busy,
    output logic                 mul_enable,
    output logic                 mul_is_signed,
    output logic [31:0]          mul_s,
    output logic [31:0]          mul_t,
    input  logic [63:0]          mul_d,
    input  logic                 mul_completed,
    output logic                 div_enable,
    output logic                 div_is_signed,
    output logic [31:0]          div_s,
    output logic [31:0]          div_t,
    input  logic [31:0]          div_q,
    input  logic [31:0]          div_r,
    input  logic                 div_completed
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   id_q;
    logic [2:0]      op_q;
    logic            neg_q;
    logic            shortcut_q;
    logic [31:0]     result_q;

    logic            grant_found;
    logic [PW-1:0]   grant_id;
    int              scan_idx;
    logic [2:0]      sel_op;
    logic [31:0]     sel_rs1;
    logic [31:0]     sel_rs2;
    logic            accept;
    logic            lr_hit;
    logic [31:0]     lr_data;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        logic signed [31:0] n;
        n = -v;
        return v[31] ? n : v;
    endfunction

    // Divide by zero and signed overflow are answered without the divider.
    function automatic logic div_special(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        return op[2] && ((b == 32'h0) ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] div_special_result(input logic [2:0] op,
                                                       input logic [31:0] a,
                                                       input logic [31:0] b);
        if (b == 32'h0)
            return op[1] ? a : 32'hFFFF_FFFF;
        return op[1] ? 32'h0 : 32'h8000_0000;
    endfunction

    // mulhsu runs unsigned on |rs1|; a negative rs1 negates the full product.
    function automatic logic [31:0] mul_select(input logic [2:0] op, input logic neg,
                                               input logic [63:0] d);
        logic signed [63:0] nd;
        nd = -$signed(d);
        case (op[1:0])
            2'd0:    return d[31:0];
            2'd2:    return neg ? nd[63:32] : d[63:32];
            default: return d[63:32];
        endcase
    endfunction

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = (int'(ptr) + i) % NREQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = PW'(scan_idx);
            end
        end
    end

    assign sel_op    = req_op[int'(grant_id)*3 +: 3];
    assign sel_rs1   = req_rs1[int'(grant_id)*32 +: 32];
    assign sel_rs2   = req_rs2[int'(grant_id)*32 +: 32];
    assign accept    = (state == S_IDLE) && grant_found;
    assign req_ready = (accept && rstn) ? onehot(grant_id) : '0;
    assign busy      = (state != S_IDLE);

`ifdef MULDIV_LASTRES_EN
    logic        lr_valid;
    logic [2:0]  lr_op;
    logic [31:0] lr_rs1, lr_rs2, lr_result;
    logic [31:0] pend_rs1, pend_rs2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lr_valid  <= 1'b0;
            lr_op     <= '0;
            lr_rs1    <= '0;
            lr_rs2    <= '0;
            lr_result <= '0;
            pend_rs1  <= '0;
            pend_rs2  <= '0;
        end else begin
            if (accept) begin
                pend_rs1 <= sel_rs1;
                pend_rs2 <= sel_rs2;
            end
            if (state == S_RESP) begin
                lr_valid  <= 1'b1;
                lr_op     <= op_q;
                lr_rs1    <= pend_rs1;
                lr_rs2    <= pend_rs2;
                lr_result <= resp_result;
            end
        end
    end

    assign lr_hit  = lr_valid && (lr_op == sel_op) && (lr_rs1 == sel_rs1) && (lr_rs2 == sel_rs2);
    assign lr_data = lr_result;
`else
    assign lr_hit  = 1'b0;
    assign lr_data = 32'h0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            ptr           <= '0;
            id_q          <= '0;
            op_q          <= '0;
            neg_q         <= 1'b0;
            shortcut_q    <= 1'b0;
            result_q      <= '0;
            resp_valid    <= '0;
            resp_result   <= '0;
            mul_enable    <= 1'b0;
            mul_is_signed <= 1'b0;
            mul_s         <= '0;
            mul_t         <= '0;
            div_enable    <= 1'b0;
            div_is_signed <= 1'b0;
            div_s         <= '0;
            div_t         <= 32'h1;
        end else begin
            mul_enable <= 1'b0;
            div_enable <= 1'b0;
            resp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        id_q  <= grant_id;
                        op_q  <= sel_op;
                        neg_q <= sel_rs1[31];
                        ptr   <= (grant_id == PW'(NREQ-1)) ? '0 : grant_id + 1'b1;
                        state <= S_ISSUE;
                        // Known answers still spend the ISSUE slot so their latency is fixed.
                        if (div_special(sel_op, sel_rs1, sel_rs2)) begin
                            shortcut_q <= 1'b1;
                            result_q   <= div_special_result(sel_op, sel_rs1, sel_rs2);
                        end else if (lr_hit) begin
                            shortcut_q <= 1'b1;
                            result_q   <= lr_data;
                        end else begin
                            shortcut_q <= 1'b0;
                            if (sel_op[2]) begin
                                div_enable    <= 1'b1;
                                div_is_signed <= !sel_op[0];
                                div_s         <= sel_rs1;
                                div_t         <= sel_rs2;
                            end else begin
                                mul_enable    <= 1'b1;
                                mul_is_signed <= !sel_op[1];
                                mul_s         <= (sel_op == 3'd2) ? abs32(sel_rs1) : sel_rs1;
                                mul_t         <= sel_rs2;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (shortcut_q) begin
                        resp_valid  <= onehot(id_q);
                        resp_result <= result_q;
                        state       <= S_RESP;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (op_q[2] ? div_completed : mul_completed) begin
                        resp_valid  <= onehot(id_q);
                        resp_result <= op_q[2] ? (op_q[1] ? div_r : div_q)
                                               : mul_select(op_q, neg_q, mul_d);
                        state       <= S_RESP;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed self-checking bench for muldiv_arbiter (NREQ=2); the mul/div units are driven by hand.
module tb_muldiv_arbiter;

    localparam int NREQ = 2;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [3*NREQ-1:0]   req_op;
    logic [32*NREQ-1:0]  req_rs1;
    logic [32*NREQ-1:0]  req_rs2;
    logic [NREQ-1:0]     resp_valid;
    logic [31:0]         resp_result;
    logic                busy;
    logic                mul_enable, mul_is_signed;
    logic [31:0]         mul_s, mul_t;
    logic [63:0]         mul_d;
    logic                mul_completed;
    logic                div_enable, div_is_signed;
    logic [31:0]         div_s, div_t, div_q, div_r;
    logic                div_completed;

    int n_vec = 0;
    int n_err = 0;
    int mul_en_cnt = 0;
    int div_en_cnt = 0;
    int rv1_cnt = 0;
    int rv_cnt = 0;

    muldiv_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .resp_valid(resp_valid), .resp_result(resp_result), .busy(busy),
        .mul_enable(mul_enable), .mul_is_signed(mul_is_signed),
        .mul_s(mul_s), .mul_t(mul_t), .mul_d(mul_d), .mul_completed(mul_completed),
        .div_enable(div_enable), .div_is_signed(div_is_signed),
        .div_s(div_s), .div_t(div_t), .div_q(div_q), .div_r(div_r),
        .div_completed(div_completed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mul_enable)     mul_en_cnt <= mul_en_cnt + 1;
        if (div_enable)     div_en_cnt <= div_en_cnt + 1;
        if (resp_valid[1])  rv1_cnt    <= rv1_cnt + 1;
        if (resp_valid != 0) rv_cnt    <= rv_cnt + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic present(input int r, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_valid[r]        = 1'b1;
        req_op[r*3 +: 3]    = op;
        req_rs1[r*32 +: 32] = a;
        req_rs2[r*32 +: 32] = b;
    endtask

    // Waits for the grant, then advances to the ISSUE cycle and withdraws the request.
    task automatic await_accept(input int r, output bit ok);
        ok = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[r]) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        req_valid[r] = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        rstn = 1'b0;
        step();
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if ({resp_valid, mul_enable, div_enable} !== 4'b0) begin n_err++; $display("FAIL reset_pulses: got %b want 0000", {resp_valid, mul_enable, div_enable}); end
        n_vec++; if (resp_result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", resp_result); end
        n_vec++; if ({mul_s, mul_t, div_s} !== 96'h0) begin n_err++; $display("FAIL reset_operands: got %h %h %h want 0 0 0", mul_s, mul_t, div_s); end
        n_vec++; if (div_t !== 32'h1) begin n_err++; $display("FAIL reset_div_t: got %h want 00000001", div_t); end
        req_valid = 2'b00;
        rstn = 1'b1;
        step();
    endtask

    task automatic test_mul();
        bit ok;
        int me0 = mul_en_cnt;
        int r10 = rv1_cnt;
        present(0, 3'd0, 32'd7, 32'hFFFF_FFFD);
        await_accept(0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL mul_accept: got no grant want grant to 0"); end
        n_vec++; if ({mul_enable, mul_is_signed, busy} !== 3'b111) begin n_err++; $display("FAIL mul_issue: got en/sgn/busy=%b want 111", {mul_enable, mul_is_signed, busy}); end
        n_vec++; if ({mul_s, mul_t} !== {32'd7, 32'hFFFF_FFFD}) begin n_err++; $display("FAIL mul_operands: got %h %h want 00000007 fffffffd", mul_s, mul_t); end
        step();
        n_vec++; if (mul_enable !== 1'b0) begin n_err++; $display("FAIL mul_enable_width: got %b want 0", mul_enable); end
        mul_d = 64'hFFFF_FFFF_FFFF_FFEB;
        mul_completed = 1'b1;
        step();
        mul_completed = 1'b0;
        n_vec++; if (resp_valid !== 2'b01) begin n_err++; $display("FAIL mul_resp_valid: got %b want 01", resp_valid); end
        n_vec++; if (resp_result !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_result: got %h want ffffffeb", resp_result); end
        step();
        n_vec++; if ({resp_valid, busy} !== 3'b000) begin n_err++; $display("FAIL mul_return_idle: got %b want 000", {resp_valid, busy}); end
        n_vec++; if (mul_en_cnt - me0 !== 1) begin n_err++; $display("FAIL mul_enable_count: got %0d want 1", mul_en_cnt - me0); end
        n_vec++; if (rv1_cnt - r10 !== 0) begin n_err++; $display("FAIL mul_resp1_quiet: got %0d want 0", rv1_cnt - r10); end
    endtask

    task automatic test_div_special();
        logic [2:0]  t_op  [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] t_a   [6] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b   [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp [6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int de0 = div_en_cnt;
        for (int i = 0; i < 6; i++) begin
            bit ok;
            int r = i % 2;
            logic [1:0] want_rv;
            want_rv = (r == 0) ? 2'b01 : 2'b10;
            present(r, t_op[i], t_a[i], t_b[i]);
            await_accept(r, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL special%0d_accept: got no grant want grant to %0d", i, r); end
            n_vec++; if ({resp_valid, busy} !== 3'b001) begin n_err++; $display("FAIL special%0d_early: got rv/busy=%b want 001", i, {resp_valid, busy}); end
            step();
            n_vec++; if (resp_valid !== want_rv) begin n_err++; $display("FAIL special%0d_resp_valid: got %b want %b", i, resp_valid, want_rv); end
            n_vec++; if (resp_result !== t_exp[i]) begin n_err++; $display("FAIL special%0d_result: got %h want %h", i, resp_result, t_exp[i]); end
            step();
        end
        n_vec++; if (div_en_cnt - de0 !== 0) begin n_err++; $display("FAIL special_div_enable: got %0d pulses want 0", div_en_cnt - de0); end
    endtask

    task automatic test_div_unit();
        logic [2:0]  t_op  [2] = '{3'd5, 3'd6};
        logic [31:0] t_a   [2] = '{32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] t_b   [2] = '{32'hFFFF_FFFF, 32'd2};
        logic        t_sgn [2] = '{1'b0, 1'b1};
        logic [31:0] t_q   [2] = '{32'd0, 32'hFFFF_FFFD};
        logic [31:0] t_r   [2] = '{32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] t_exp [2] = '{32'd0, 32'hFFFF_FFFF};
        for (int i = 0; i < 2; i++) begin
            bit ok;
            present(0, t_op[i], t_a[i], t_b[i]);
            await_accept(0, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL divu%0d_accept: got no grant want grant to 0", i); end
            n_vec++; if ({div_enable, div_is_signed} !== {1'b1, t_sgn[i]}) begin n_err++; $display("FAIL divu%0d_issue: got en/sgn=%b want %b", i, {div_enable, div_is_signed}, {1'b1, t_sgn[i]}); end
            n_vec++; if ({div_s, div_t} !== {t_a[i], t_b[i]}) begin n_err++; $display("FAIL divu%0d_operands: got %h %h want %h %h", i, div_s, div_t, t_a[i], t_b[i]); end
            step();
            mul_d = 64'h1234;
            mul_completed = 1'b1;
            step();
            mul_completed = 1'b0;
            n_vec++; if ({resp_valid, busy} !== 3'b001) begin n_err++; $display("FAIL divu%0d_stray_mul: got rv/busy=%b want 001", i, {resp_valid, busy}); end
            div_q = t_q[i];
            div_r = t_r[i];
            div_completed = 1'b1;
            step();
            div_completed = 1'b0;
            n_vec++; if (resp_valid !== 2'b01) begin n_err++; $display("FAIL divu%0d_resp_valid: got %b want 01", i, resp_valid); end
            n_vec++; if (resp_result !== t_exp[i]) begin n_err++; $display("FAIL divu%0d_result: got %h want %h", i, resp_result, t_exp[i]); end
            step();
        end
    endtask

    task automatic test_mul_high();
        logic [2:0]  t_op  [4] = '{3'd2, 3'd2, 3'd1, 3'd3};
        logic [31:0] t_a   [4] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_b   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2};
        logic [31:0] t_s   [4] = '{32'd1, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic        t_sgn [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [63:0] t_d   [4] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0001_FFFF_FFFE,
                                   64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_FFFF_FFFE};
        logic [31:0] t_exp [4] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1};
        for (int i = 0; i < 4; i++) begin
            bit ok;
            present(1, t_op[i], t_a[i], t_b[i]);
            await_accept(1, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL mulh%0d_accept: got no grant want grant to 1", i); end
            n_vec++; if ({mul_enable, mul_is_signed} !== {1'b1, t_sgn[i]}) begin n_err++; $display("FAIL mulh%0d_issue: got en/sgn=%b want %b", i, {mul_enable, mul_is_signed}, {1'b1, t_sgn[i]}); end
            n_vec++; if ({mul_s, mul_t} !== {t_s[i], t_b[i]}) begin n_err++; $display("FAIL mulh%0d_operands: got %h %h want %h %h", i, mul_s, mul_t, t_s[i], t_b[i]); end
            step();
            div_completed = 1'b1;
            step();
            div_completed = 1'b0;
            n_vec++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL mulh%0d_stray_div: got %b want 00", i, resp_valid); end
            mul_d = t_d[i];
            mul_completed = 1'b1;
            step();
            mul_completed = 1'b0;
            n_vec++; if ({resp_valid, resp_result} !== {2'b10, t_exp[i]}) begin n_err++; $display("FAIL mulh%0d_resp: got %b %h want 10 %h", i, resp_valid, resp_result, t_exp[i]); end
            step();
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        present(0, 3'd0, 32'd3, 32'd4);
        present(1, 3'd0, 32'd5, 32'd6);
        #1;
        for (int g = 0; g < 4; g++) begin
            logic [1:0]  want_g;
            logic [1:0]  got_g;
            logic [31:0] prod;
            want_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            prod   = (g % 2 == 0) ? 32'd12 : 32'd30;
            got_g  = 2'b00;
            for (int w = 0; w < 10; w++) begin
                if (req_ready != 2'b00) begin
                    got_g = req_ready;
                    break;
                end
                step();
            end
            n_vec++; if (got_g !== want_g) begin n_err++; $display("FAIL rr%0d_grant: got %b want %b", g, got_g, want_g); end
            step();
            step();
            mul_d = {32'h0, prod};
            mul_completed = 1'b1;
            step();
            mul_completed = 1'b0;
            n_vec++; if ({resp_valid, resp_result} !== {want_g, prod}) begin n_err++; $display("FAIL rr%0d_resp: got %b %h want %b %h", g, resp_valid, resp_result, want_g, prod); end
            if (g == 3) req_valid = 2'b00;
            step();
        end
    endtask

    task automatic test_lastres();
        bit ok;
        int me0 = mul_en_cnt;
        present(0, 3'd0, 32'd5, 32'd6);
        await_accept(0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL lastres_accept: got no grant want grant to 0"); end
`ifdef MULDIV_LASTRES_EN
        step();
        n_vec++; if ({resp_valid, resp_result} !== {2'b01, 32'd30}) begin n_err++; $display("FAIL lastres_hit: got %b %h want 01 0000001e", resp_valid, resp_result); end
        n_vec++; if (mul_en_cnt - me0 !== 0) begin n_err++; $display("FAIL lastres_enable: got %0d pulses want 0", mul_en_cnt - me0); end
`else
        n_vec++; if (mul_enable !== 1'b1) begin n_err++; $display("FAIL repeat_issue: got %b want 1", mul_enable); end
        step();
        mul_d = 64'd30;
        mul_completed = 1'b1;
        step();
        mul_completed = 1'b0;
        n_vec++; if ({resp_valid, resp_result} !== {2'b01, 32'd30}) begin n_err++; $display("FAIL repeat_resp: got %b %h want 01 0000001e", resp_valid, resp_result); end
`endif
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int rv0 = rv_cnt;
        present(1, 3'd0, 32'd9, 32'd9);
        await_accept(1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL midrst_accept: got no grant want grant to 1"); end
        step();
        rstn = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy_async: got %b want 0", busy); end
        step();
        rstn = 1'b1;
        mul_d = 64'd81;
        mul_completed = 1'b1;
        step();
        mul_completed = 1'b0;
        step();
        n_vec++; if ({resp_valid, busy} !== 3'b000) begin n_err++; $display("FAIL midrst_idle: got rv/busy=%b want 000", {resp_valid, busy}); end
        n_vec++; if (rv_cnt - rv0 !== 0) begin n_err++; $display("FAIL midrst_no_resp: got %0d responses want 0", rv_cnt - rv0); end
        present(0, 3'd4, 32'd5, 32'd0);
        await_accept(0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL midrst_next_accept: got no grant want grant to 0"); end
        step();
        n_vec++; if ({resp_valid, resp_result} !== {2'b01, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL midrst_next_resp: got %b %h want 01 ffffffff", resp_valid, resp_result); end
        step();
    endtask

    initial begin
        req_valid     = '0;
        req_op        = '0;
        req_rs1       = '0;
        req_rs2       = '0;
        mul_d         = '0;
        mul_completed = 1'b0;
        div_q         = '0;
        div_r         = '0;
        div_completed = 1'b0;
        test_reset();
        test_mul();
        test_div_special();
        test_div_unit();
        test_mul_high();
        test_round_robin();
        test_lastres();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
